// File: rtl/btn_event_conditioner_if.sv
// Button conditioner bus: raw buttons and game_tick in, conditioned levels,
// tick-aligned events, jump charge and debug press counters out.
interface btn_event_conditioner_if #(
  parameter int CHARGE_WIDTH = 8
);
  logic                    left_btn;
  logic                    right_btn;
  logic                    jump_btn;
  logic                    game_tick;
  logic                    left_level;
  logic                    right_level;
  logic                    jump_level;
  logic                    left_evt;
  logic                    right_evt;
  logic                    jump_charging;
  logic                    jump_fire;
  logic [CHARGE_WIDTH-1:0] jump_charge;
  logic [15:0]             left_cnt;
  logic [15:0]             right_cnt;
  logic [15:0]             jump_cnt;

  modport master (
    output left_btn, right_btn, jump_btn, game_tick,
    input  left_level, right_level, jump_level, left_evt, right_evt,
    input  jump_charging, jump_fire, jump_charge, left_cnt, right_cnt, jump_cnt
  );

  modport slave (
    input  left_btn, right_btn, jump_btn, game_tick,
    output left_level, right_level, jump_level, left_evt, right_evt,
    output jump_charging, jump_fire, jump_charge, left_cnt, right_cnt, jump_cnt
  );
endinterface

// File: rtl/btn_event_conditioner.sv
// Button sync/debounce, tick re-timing of press events and jump charge FSM.
// Define BTN_EVT_CNT_EN to build the 16-bit debug press counters.

// One button lane: 2-FF synchroniser, debouncer, registered rise/fall pulses.
module btn_event_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]     sync_pipe;
  logic [DBW-1:0] db_cnt;
  logic           differ;
  logic           accept;

  assign differ = sync_pipe[1] ^ level;
  assign accept = differ && (db_cnt == DBW'(DB_CYCLES - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_pipe <= '0;
      db_cnt    <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      // Any return to the stable value restarts the window.
      if (!differ || accept) db_cnt <= '0;
      else                   db_cnt <= db_cnt + 1'b1;
      if (accept) level <= sync_pipe[1];
      rise <= accept &  sync_pipe[1];
      fall <= accept & ~sync_pipe[1];
    end
  end
endmodule

module btn_event_conditioner #(
  parameter int DB_CYCLES    = 1000000,
  parameter int CHARGE_WIDTH = 8,
  parameter int CHARGE_MAX   = 255
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  btn_event_conditioner_if.slave  bus
);
  localparam int NUM_BTN = 3;  // lane 0 left, 1 right, 2 jump

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_RELEASE} jstate_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic               unused_fall;
  logic               tick;

  assign raw         = {bus.jump_btn, bus.right_btn, bus.left_btn};
  assign tick        = bus.game_tick & ~sys_rst;
  assign unused_fall = ^fall[1:0];

  btn_event_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .raw     (raw),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  assign bus.left_level  = level[0];
  assign bus.right_level = level[1];
  assign bus.jump_level  = level[2];

  // Sticky pending press; a rise coinciding with the tick is reported directly.
  logic [1:0] pend;
  logic [1:0] evt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)             pend <= '0;
    else if (bus.game_tick)  pend <= '0;
    else                     pend <= pend | rise[1:0];
  end

  assign evt           = {2{tick}} & (pend | rise[1:0]);
  assign bus.left_evt  = evt[0];
  assign bus.right_evt = evt[1];

  // Jump charge FSM
  jstate_t                 state;
  jstate_t                 state_nxt;
  logic [CHARGE_WIDTH-1:0] charge_cnt;
  logic [CHARGE_WIDTH-1:0] charge_hold;
  logic                    charging_q;
  logic                    fire;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      charging_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      charging_q <= (state_nxt == S_CHARGE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rise[2]) state_nxt = S_CHARGE;
      S_CHARGE:  if (fall[2]) state_nxt = S_RELEASE;
      S_RELEASE: if (tick)    state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fire = 1'b0;
    if (state == S_RELEASE) fire = tick;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      charge_cnt  <= '0;
      charge_hold <= '0;
    end else begin
      if (state == S_IDLE && rise[2])
        charge_cnt <= '0;
      else if (state == S_CHARGE && tick && charge_cnt != CHARGE_WIDTH'(CHARGE_MAX))
        charge_cnt <= charge_cnt + 1'b1;
      if (fire) charge_hold <= charge_cnt;
    end
  end

  assign bus.jump_charging = charging_q;
  assign bus.jump_fire     = fire;
  assign bus.jump_charge   = fire ? charge_cnt : charge_hold;

`ifdef BTN_EVT_CNT_EN
  logic [NUM_BTN-1:0][15:0] press_cnt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_cnt
    always_ff @(posedge sys_clk) begin
      if (sys_rst)      press_cnt[g] <= '0;
      else if (rise[g]) press_cnt[g] <= press_cnt[g] + 16'd1;
    end
  end

  assign bus.left_cnt  = press_cnt[0];
  assign bus.right_cnt = press_cnt[1];
  assign bus.jump_cnt  = press_cnt[2];
`else
  assign bus.left_cnt  = 16'd0;
  assign bus.right_cnt = 16'd0;
  assign bus.jump_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_btn_event_conditioner.sv
// Directed bench for btn_event_conditioner with DB_CYCLES=4, CHARGE_MAX=5.
module tb_btn_event_conditioner;
  logic sys_clk = 1'b0;
  logic sys_rst;
  int   checks   = 0;
  int   failures = 0;

`ifdef BTN_EVT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  btn_event_conditioner_if #(.CHARGE_WIDTH(8)) bus ();

  btn_event_conditioner #(
    .DB_CYCLES    (4),
    .CHARGE_WIDTH (8),
    .CHARGE_MAX   (5)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One-cycle tick; expected fire/evt/charge checked while it is high.
  task automatic tick_chk(input string tag, input logic exp_l, input logic exp_r,
                          input logic exp_f, input logic chk_q, input logic [7:0] exp_q);
    bus.game_tick = 1'b1;
    #1;
    chk({tag, "_levt"}, {31'd0, bus.left_evt},  {31'd0, exp_l});
    chk({tag, "_revt"}, {31'd0, bus.right_evt}, {31'd0, exp_r});
    chk({tag, "_fire"}, {31'd0, bus.jump_fire}, {31'd0, exp_f});
    if (chk_q) chk({tag, "_charge"}, {24'd0, bus.jump_charge}, {24'd0, exp_q});
    @(negedge sys_clk);
    bus.game_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    #1;
    chk({tag, "_levels"}, {29'd0, bus.left_level, bus.right_level, bus.jump_level}, 32'd0);
    chk({tag, "_evts"},   {29'd0, bus.left_evt, bus.right_evt, bus.jump_fire}, 32'd0);
    chk({tag, "_chg"},    {31'd0, bus.jump_charging}, 32'd0);
    chk({tag, "_charge"}, {24'd0, bus.jump_charge}, 32'd0);
    chk({tag, "_cnts"},   {bus.left_cnt | bus.right_cnt | bus.jump_cnt, 16'd0}, 32'd0);
  endtask

  initial begin
    logic seen;
    sys_rst       = 1'b1;
    bus.left_btn  = 1'b0;
    bus.right_btn = 1'b0;
    bus.jump_btn  = 1'b0;
    bus.game_tick = 1'b0;
    cyc(3);
    chk_all_zero("reset");
    sys_rst = 1'b0;
    cyc(2);

    // 3-cycle glitch never reaches the level
    bus.left_btn = 1'b1;
    cyc(3);
    bus.left_btn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); seen |= bus.left_level; end
    chk("glitch_level", {31'd0, seen}, 32'd0);
    tick_chk("glitch_tick", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Held press: level appears on the 6th cycle
    bus.left_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin cyc(1); seen |= bus.left_level; end
    chk("hold_early", {31'd0, seen}, 32'd0);
    cyc(1);
    chk("hold_level", {31'd0, bus.left_level}, 32'd1);
    cyc(4);
    tick_chk("hold_tick", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc(2);
    tick_chk("hold_tick2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    bus.left_btn = 1'b0;
    cyc(10);

    // Press and release well before the tick
    bus.right_btn = 1'b1;
    cyc(10);
    bus.right_btn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin cyc(1); seen |= bus.right_evt; end
    chk("retime_quiet", {31'd0, seen}, 32'd0);
    tick_chk("retime_tick", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    #1 chk("retime_after", {31'd0, bus.right_evt}, 32'd0);

    // Three presses between ticks collapse to one event
    for (int p = 0; p < 3; p++) begin
      bus.right_btn = 1'b1; cyc(8);
      bus.right_btn = 1'b0; cyc(8);
    end
    tick_chk("multi_tick", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    cyc(3);
    tick_chk("multi_tick2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    #1 chk("right_cnt", {16'd0, bus.right_cnt}, CNT_EN ? 32'd4 : 32'd0);

    // Charge across 3 ticks
    bus.jump_btn = 1'b1;
    cyc(8);
    #1 chk("chg_charging", {31'd0, bus.jump_charging}, 32'd1);
    for (int t = 0; t < 3; t++) begin
      tick_chk("chg_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(3);
    end
    bus.jump_btn = 1'b0;
    cyc(10);
    #1 chk("chg_released", {31'd0, bus.jump_charging}, 32'd0);
    tick_chk("chg_fire", 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    #1 chk("chg_after_fire", {31'd0, bus.jump_fire}, 32'd0);
    chk("chg_hold", {24'd0, bus.jump_charge}, 32'd3);
    chk("chg_idle", {31'd0, bus.jump_charging}, 32'd0);
    cyc(2);

    // Saturation at CHARGE_MAX
    bus.jump_btn = 1'b1;
    cyc(8);
    for (int t = 0; t < 8; t++) begin
      tick_chk("sat_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(2);
    end
    bus.jump_btn = 1'b0;
    cyc(10);
    tick_chk("sat_fire", 1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    cyc(2);

    // Release pulse coincides with the 2nd tick
    bus.jump_btn = 1'b1;
    cyc(8);
    tick_chk("sim_t1", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc(2);
    bus.jump_btn = 1'b0;
    cyc(5);
    #1 chk("sim_pre_level", {31'd0, bus.jump_level}, 32'd1);
    cyc(1);
    #1 chk("sim_fall_level", {31'd0, bus.jump_level}, 32'd0);
    chk("sim_still_chg", {31'd0, bus.jump_charging}, 32'd1);
    tick_chk("sim_t2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc(3);
    #1 chk("sim_release", {31'd0, bus.jump_charging}, 32'd0);
    tick_chk("sim_t3", 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    cyc(2);
    #1 chk("jump_cnt", {16'd0, bus.jump_cnt}, CNT_EN ? 32'd3 : 32'd0);

    // Rise in the tick cycle is reported directly, not left pending
    bus.left_btn = 1'b1;
    cyc(6);
    #1 chk("same_level", {31'd0, bus.left_level}, 32'd1);
    tick_chk("same_tick", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc(2);
    tick_chk("same_tick2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    bus.left_btn = 1'b0;
    cyc(10);
    #1 chk("left_cnt", {16'd0, bus.left_cnt}, CNT_EN ? 32'd2 : 32'd0);

    // Reset while a fire is pending in RELEASE
    bus.jump_btn = 1'b1;
    cyc(8);
    tick_chk("rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    bus.jump_btn = 1'b0;
    cyc(10);
    #1 chk("rst_in_release", {31'd0, bus.jump_charging}, 32'd0);
    sys_rst = 1'b1;
    cyc(1);
    sys_rst = 1'b0;
    chk_all_zero("rst_mid");
    cyc(1);
    tick_chk("rst_no_fire", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
